// File: rtl/ram_ctrl_pkg.sv
// Shared types and constants for the single-port RAM sequencer.
package ram_ctrl_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH = 3;
    localparam int WR_SEQ_CYCLES  = 3;

    typedef enum logic [3:0] {
        IDLE,
        WR_SETUP,
        WR_STROBE,
        WR_HOLD,
        RD_SETUP,
        RD_CAPTURE,
        RESP,
        INIT_SETUP,
        INIT_STROBE,
        INIT_HOLD
    } state_t;

endpackage

// File: rtl/ram_ctrl_if.sv
// Request/response handshake channels between upstream logic and ram_ctrl.
interface ram_ctrl_if
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
);
    logic                  req_valid_in;
    logic                  req_ready_out;
    logic                  req_write_in;
    logic [ADDR_WIDTH-1:0] req_addr_in;
    logic [DATA_WIDTH-1:0] req_wdata_in;
    logic                  rsp_valid_out;
    logic                  rsp_ready_in;
    logic [DATA_WIDTH-1:0] rsp_rdata_out;

    modport master (
        output req_valid_in, req_write_in, req_addr_in, req_wdata_in, rsp_ready_in,
        input  req_ready_out, rsp_valid_out, rsp_rdata_out
    );

    modport slave (
        input  req_valid_in, req_write_in, req_addr_in, req_wdata_in, rsp_ready_in,
        output req_ready_out, rsp_valid_out, rsp_rdata_out
    );
endinterface

// File: rtl/ram_bus_drv.sv
// Tri-state driver for the shared RAM data bus; the only place Z is produced.
module ram_bus_drv
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
    input  logic                  drive_en,
    input  logic [DATA_WIDTH-1:0] wdata,
    inout  wire  [DATA_WIDTH-1:0] bus,
    output logic [DATA_WIDTH-1:0] sampled
);
    assign bus     = drive_en ? wdata : 'z;
    assign sampled = bus;
endmodule

// File: rtl/ram_ctrl.sv
// Sequencer for the single-port RAM: setup/strobe/hold timing, bus ownership, read capture.
// Optional power-up sweep writing INIT_VALUE to every location: define RAM_INIT_EN.
module ram_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    ram_ctrl_if.slave             bus,
    output logic                  ram_we_out,
    output logic                  ram_enable_out,
    output logic [ADDR_WIDTH-1:0] ram_addr_out,
    inout  wire  [DATA_WIDTH-1:0] ram_data
);

`ifdef RAM_INIT_EN
    localparam state_t RESET_STATE = INIT_SETUP;
`else
    localparam state_t RESET_STATE = IDLE;
`endif

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q, rdata_q, bus_sample;
    logic                  drive_en, accept, capture, ready, rsp_valid;

    always_ff @(posedge clk_in) begin
        if (rst_in) state <= RESET_STATE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        ready          = 1'b0;
        accept         = 1'b0;
        capture        = 1'b0;
        drive_en       = 1'b0;
        ram_we_out     = 1'b0;
        ram_enable_out = 1'b0;
        rsp_valid      = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (bus.req_valid_in) begin
                    accept    = 1'b1;
                    state_nxt = bus.req_write_in ? WR_SETUP : RD_SETUP;
                end
            end
            WR_SETUP: begin
                drive_en  = 1'b1;
                state_nxt = WR_STROBE;
            end
            WR_STROBE: begin
                drive_en   = 1'b1;
                ram_we_out = 1'b1;
                state_nxt  = WR_HOLD;
            end
            WR_HOLD: begin
                drive_en  = 1'b1;
                state_nxt = IDLE;
            end
            RD_SETUP: begin
                ram_enable_out = 1'b1;
                state_nxt      = RD_CAPTURE;
            end
            RD_CAPTURE: begin
                ram_enable_out = 1'b1;
                capture        = 1'b1;
                state_nxt      = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready_in) state_nxt = IDLE;
            end
`ifdef RAM_INIT_EN
            // Reset parks the sweep here, so keep the bus released until reset drops.
            INIT_SETUP: begin
                drive_en  = !rst_in;
                state_nxt = INIT_STROBE;
            end
            INIT_STROBE: begin
                drive_en   = 1'b1;
                ram_we_out = 1'b1;
                state_nxt  = INIT_HOLD;
            end
            INIT_HOLD: begin
                drive_en  = 1'b1;
                state_nxt = (addr_q == '1) ? IDLE : INIT_SETUP;
            end
`endif
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            addr_q  <= '0;
            wdata_q <= INIT_VALUE;
            rdata_q <= '0;
        end else begin
            if (accept) begin
                addr_q  <= bus.req_addr_in;
                wdata_q <= bus.req_wdata_in;
            end
            if (capture) rdata_q <= bus_sample;
`ifdef RAM_INIT_EN
            if (state == INIT_HOLD && addr_q != '1) addr_q <= addr_q + 1'b1;
`endif
        end
    end

    ram_bus_drv #(.DATA_WIDTH(DATA_WIDTH)) u_bus_drv (
        .drive_en (drive_en),
        .wdata    (wdata_q),
        .bus      (ram_data),
        .sampled  (bus_sample)
    );

    assign ram_addr_out      = addr_q;
    assign bus.req_ready_out = ready & ~rst_in;
    assign bus.rsp_valid_out = rsp_valid;
    assign bus.rsp_rdata_out = rdata_q;

endmodule

// File: tb/tb_ram_ctrl.sv
// Bench for ram_ctrl: behavioural single-port RAM on the shared bus plus an array reference model.
module tb_ram_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       ram_we, ram_en;
    logic [2:0] ram_addr;
    wire  [7:0] ram_data;

    logic [7:0] ram_mem [8];
    logic [7:0] ref_mem [8];
    bit         ref_ok  [8];
    int         checks   = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    ram_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) rif ();

    ram_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .INIT_VALUE(8'h5A)) dut (
        .clk_in         (clk),
        .rst_in         (rst),
        .bus            (rif),
        .ram_we_out     (ram_we),
        .ram_enable_out (ram_en),
        .ram_addr_out   (ram_addr),
        .ram_data       (ram_data)
    );

    // Single-port RAM: writes when we=1/enable=0, drives the bus when enable=1/we=0.
    assign ram_data = (ram_en && !ram_we) ? ram_mem[ram_addr] : 'z;
    always @(posedge clk) if (ram_we && !ram_en) ram_mem[ram_addr] <= ram_data;

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (ram_we && ram_en) begin
                failures++;
                $display("FAIL strobe_excl: we=%b en=%b, required not both 1", ram_we, ram_en);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
        $fatal(1);
    end

    task automatic run_write(input logic [2:0] a, input logic [7:0] d);
        rif.req_valid_in = 1'b1; rif.req_write_in = 1'b1;
        rif.req_addr_in  = a;    rif.req_wdata_in = d;
        checks++; if (rif.req_ready_out !== 1'b1) begin failures++; $display("FAIL wr_accept: ready=%b required 1", rif.req_ready_out); end
        @(negedge clk);
        rif.req_valid_in = 1'b0; rif.req_wdata_in = ~d;
        checks++; if ({ram_we, ram_en, rif.req_ready_out, ram_addr, ram_data} !== {3'b000, a, d}) begin failures++;
            $display("FAIL wr_setup: we/en/rdy/addr/data=%b%b%b/%0d/%h required 000/%0d/%h", ram_we, ram_en, rif.req_ready_out, ram_addr, ram_data, a, d); end
        @(negedge clk);
        checks++; if ({ram_we, ram_en, rif.req_ready_out, ram_addr, ram_data} !== {3'b100, a, d}) begin failures++;
            $display("FAIL wr_strobe: we/en/rdy/addr/data=%b%b%b/%0d/%h required 100/%0d/%h", ram_we, ram_en, rif.req_ready_out, ram_addr, ram_data, a, d); end
        @(negedge clk);
        checks++; if ({ram_we, ram_en, rif.req_ready_out, ram_addr, ram_data} !== {3'b000, a, d}) begin failures++;
            $display("FAIL wr_hold: we/en/rdy/addr/data=%b%b%b/%0d/%h required 000/%0d/%h", ram_we, ram_en, rif.req_ready_out, ram_addr, ram_data, a, d); end
        @(negedge clk);
        checks++; if ({ram_we, ram_en, rif.req_ready_out} !== 3'b001) begin failures++;
            $display("FAIL wr_done: we/en/rdy=%b%b%b required 001", ram_we, ram_en, rif.req_ready_out); end
        ref_mem[a] = d;
        ref_ok[a]  = 1'b1;
    endtask

    task automatic run_read(input logic [2:0] a, input int stall);
        logic [7:0] exp;
        exp = ref_mem[a];
        rif.rsp_ready_in = (stall == 0);
        rif.req_valid_in = 1'b1; rif.req_write_in = 1'b0;
        rif.req_addr_in  = a;    rif.req_wdata_in = 8'($urandom);
        checks++; if (rif.req_ready_out !== 1'b1) begin failures++; $display("FAIL rd_accept: ready=%b required 1", rif.req_ready_out); end
        @(negedge clk);
        rif.req_valid_in = 1'b0;
        checks++; if ({ram_we, ram_en, rif.req_ready_out, rif.rsp_valid_out, ram_addr} !== {4'b0100, a}) begin failures++;
            $display("FAIL rd_setup: we/en/rdy/vld/addr=%b%b%b%b/%0d required 0100/%0d", ram_we, ram_en, rif.req_ready_out, rif.rsp_valid_out, ram_addr, a); end
        @(negedge clk);
        checks++; if ({ram_we, ram_en, rif.rsp_valid_out, ram_data} !== {3'b010, exp}) begin failures++;
            $display("FAIL rd_capture: we/en/vld/bus=%b%b%b/%h required 010/%h", ram_we, ram_en, rif.rsp_valid_out, ram_data, exp); end
        @(negedge clk);
        checks++; if ({ram_en, rif.req_ready_out, rif.rsp_valid_out, rif.rsp_rdata_out} !== {3'b001, exp}) begin failures++;
            $display("FAIL rd_resp: en/rdy/vld/rdata=%b%b%b/%h required 001/%h", ram_en, rif.req_ready_out, rif.rsp_valid_out, rif.rsp_rdata_out, exp); end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++; if ({rif.req_ready_out, rif.rsp_valid_out, rif.rsp_rdata_out} !== {2'b01, exp}) begin failures++;
                $display("FAIL rd_stall%0d: rdy/vld/rdata=%b%b/%h required 01/%h", i, rif.req_ready_out, rif.rsp_valid_out, rif.rsp_rdata_out, exp); end
        end
        rif.rsp_ready_in = 1'b1;
        @(negedge clk);
        checks++; if ({rif.req_ready_out, rif.rsp_valid_out, ram_en} !== 3'b100) begin failures++;
            $display("FAIL rd_done: rdy/vld/en=%b%b%b required 100", rif.req_ready_out, rif.rsp_valid_out, ram_en); end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        rif.req_valid_in = 1'b0; rif.req_write_in = 1'b0; rif.req_addr_in = '0;
        rif.req_wdata_in = '0;   rif.rsp_ready_in = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if ({rif.req_ready_out, ram_we, ram_en, ram_addr, rif.rsp_valid_out, rif.rsp_rdata_out} !== 15'd0) begin failures++;
            $display("FAIL reset_vals: rdy/we/en/addr/vld/rdata=%b%b%b/%0d/%b/%h required 000/0/0/00",
                     rif.req_ready_out, ram_we, ram_en, ram_addr, rif.rsp_valid_out, rif.rsp_rdata_out); end
        rst = 1'b0;
        #1;
`ifdef RAM_INIT_EN
        checks++; if (rif.req_ready_out !== 1'b0) begin failures++; $display("FAIL reset_release: ready=%b required 0", rif.req_ready_out); end
`else
        checks++; if (rif.req_ready_out !== 1'b1) begin failures++; $display("FAIL reset_release: ready=%b required 1", rif.req_ready_out); end
`endif
    endtask

`ifdef RAM_INIT_EN
    task automatic test_init;
        int strobes;
        strobes = 0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        for (int i = 0; i < 24; i++) begin
            if (i > 0) @(negedge clk);
            checks++; if (rif.req_ready_out !== 1'b0) begin failures++; $display("FAIL init_busy%0d: ready=%b required 0", i, rif.req_ready_out); end
            if (ram_we) begin
                checks++; if ({ram_addr, ram_data} !== {3'(strobes), 8'h5A}) begin failures++;
                    $display("FAIL init_strobe%0d: addr/data=%0d/%h required %0d/5a", strobes, ram_addr, ram_data, strobes); end
                strobes++;
            end
        end
        @(negedge clk);
        checks++; if (rif.req_ready_out !== 1'b1) begin failures++; $display("FAIL init_done: ready=%b required 1", rif.req_ready_out); end
        checks++; if (strobes != 8) begin failures++; $display("FAIL init_count: strobes=%0d required 8", strobes); end
        for (int a = 0; a < 8; a++) begin
            ref_mem[a] = 8'h5A;
            ref_ok[a]  = 1'b1;
        end
        for (int a = 0; a < 8; a++) run_read(3'(a), 0);
    endtask
`endif

    task automatic test_write_read;
        run_write(3'd5, 8'hA5);
        run_read(3'd5, 0);
    endtask

    task automatic test_back_to_back;
        rif.req_valid_in = 1'b1; rif.req_write_in = 1'b1;
        rif.req_addr_in  = 3'd0; rif.req_wdata_in = 8'h3C;
        @(negedge clk);
        rif.req_write_in = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            checks++; if ({rif.req_ready_out, ram_en, ram_data} !== {2'b00, 8'h3C}) begin failures++;
                $display("FAIL b2b_wr%0d: rdy/en/bus=%b%b/%h required 00/3c", i, rif.req_ready_out, ram_en, ram_data); end
            @(negedge clk);
        end
        checks++; if ({rif.req_ready_out, ram_we, ram_en} !== 3'b100) begin failures++;
            $display("FAIL b2b_gap: rdy/we/en=%b%b%b required 100", rif.req_ready_out, ram_we, ram_en); end
        @(negedge clk);
        rif.req_valid_in = 1'b0;
        checks++; if ({ram_we, ram_en} !== 2'b01) begin failures++; $display("FAIL b2b_rd_setup: we/en=%b%b required 01", ram_we, ram_en); end
        @(negedge clk);
        checks++; if (ram_data !== 8'h3C) begin failures++; $display("FAIL b2b_rd_bus: bus=%h required 3c", ram_data); end
        @(negedge clk);
        checks++; if ({rif.rsp_valid_out, rif.rsp_rdata_out} !== {1'b1, 8'h3C}) begin failures++;
            $display("FAIL b2b_resp: vld/rdata=%b/%h required 1/3c", rif.rsp_valid_out, rif.rsp_rdata_out); end
        @(negedge clk);
        ref_mem[0] = 8'h3C;
        ref_ok[0]  = 1'b1;
    endtask

    task automatic test_backpressure;
        run_write(3'd7, 8'h11);
        run_read(3'd7, 5);
    endtask

    task automatic test_random;
        logic [2:0] a;
        bit         wr;
        for (int n = 0; n < 30; n++) begin
            a  = 3'($urandom_range(0, 7));
            wr = ($urandom_range(0, 1) == 1) || !ref_ok[a];
            if (wr) run_write(a, 8'($urandom));
            else    run_read(a, int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_mid_read;
        rif.req_valid_in = 1'b1; rif.req_write_in = 1'b0; rif.req_addr_in = 3'd5;
        @(negedge clk);
        rif.req_valid_in = 1'b0;
        @(negedge clk);
        checks++; if (ram_en !== 1'b1) begin failures++; $display("FAIL mid_rd_capture: en=%b required 1", ram_en); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
`ifdef RAM_INIT_EN
        checks++; if ({rif.rsp_valid_out, ram_we, ram_en, rif.req_ready_out} !== 4'b0000) begin failures++;
            $display("FAIL mid_rd_after: vld/we/en/rdy=%b%b%b%b required 0000", rif.rsp_valid_out, ram_we, ram_en, rif.req_ready_out); end
`else
        checks++; if ({rif.rsp_valid_out, ram_we, ram_en, rif.req_ready_out} !== 4'b0001) begin failures++;
            $display("FAIL mid_rd_after: vld/we/en/rdy=%b%b%b%b required 0001", rif.rsp_valid_out, ram_we, ram_en, rif.req_ready_out); end
`endif
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if (rif.rsp_valid_out !== 1'b0) begin failures++; $display("FAIL mid_rd_drop%0d: vld=%b required 0", i, rif.rsp_valid_out); end
        end
    endtask

    initial begin
        for (int a = 0; a < 8; a++) ref_ok[a] = 1'b0;
        test_reset();
`ifdef RAM_INIT_EN
        test_init();
`endif
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
